// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter giving two requesters access to a
// register bank. Optional write guard enabled by macro REG_ARB_RO_GUARD_EN.
module reg_bus_arbiter (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        wide0,
  input  logic        wide1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        g_wrb,
  output logic        g_rdb,
  output logic [4:0]  g_dout_w0x0f,
  output logic [63:0] din,
  output logic        n9_bit_write,
  input  logic [31:0] g_dout
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        idx_q, idx_d;
  logic        we_q, we_d;
  logic        pair_q, pair_d;
  logic        rej_q, rej_d;
  logic [4:0]  cad_q, cad_d;
  logic [63:0] cdat_q, cdat_d;

  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic        wrb_q, wrb_d;
  logic        rdb_q, rdb_d;
  logic [4:0]  addr_q, addr_d;
  logic [63:0] din_q, din_d;
  logic        n9_q, n9_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        sel;
  logic        sel_we;
  logic        sel_pair;
  logic        sel_rej;
  logic [4:0]  sel_addr;
  logic [63:0] sel_data;

  // Pick the winner (the one not granted last on a tie) and mux its request
  always_comb begin
    sel      = (req0 & req1) ? ~rr_q : req1;
    sel_we   = sel ? we1 : we0;
    sel_addr = sel ? addr1 : addr0;
    sel_pair = (sel ? wide1 : wide0) & sel_we;
    sel_data = sel ? wdata1 : wdata0;
    if (!sel_pair) begin
      sel_data[63:32] = 32'h0;
    end
`ifdef REG_ARB_RO_GUARD_EN
    sel_rej  = sel_we & ((sel_addr == 5'h09) |
                         (sel_addr == 5'h0B) |
                         (sel_addr > 5'h17)  |
                         (sel_pair & sel_addr[0]));
`else
    sel_rej  = 1'b0;
`endif
  end

`ifdef REG_ARB_RO_GUARD_EN
  logic [1:0] err_q, err_d;
`endif

  // Next state, capture of the granted request and registered outputs
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    we_d     = we_q;
    pair_d   = pair_q;
    rej_d    = rej_q;
    cad_d    = cad_q;
    cdat_d   = cdat_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
`ifdef REG_ARB_RO_GUARD_EN
    err_d    = 2'b00;
`endif
    wrb_d    = 1'b1;
    rdb_d    = 1'b1;
    addr_d   = 5'h0;
    din_d    = 64'h0;
    n9_d     = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (req0 | req1) begin
          state_d    = SETUP;
          rr_d       = sel;
          idx_d      = sel;
          we_d       = sel_we;
          pair_d     = sel_pair;
          rej_d      = sel_rej;
          cad_d      = sel_addr;
          cdat_d     = sel_data;
          gnt_d[sel] = 1'b1;
          addr_d     = sel_addr;
          din_d      = sel_data;
          n9_d       = sel_pair;
        end
      end
      SETUP: begin
        state_d = STROBE;
        addr_d  = cad_q;
        din_d   = cdat_q;
        n9_d    = pair_q;
        wrb_d   = ~(we_q & ~rej_q);
        rdb_d   = we_q;
      end
      STROBE: begin
        state_d       = DONE;
        done_d[idx_q] = 1'b1;
`ifdef REG_ARB_RO_GUARD_EN
        err_d[idx_q]  = rej_q;
`endif
        if (!we_q) begin
          if (idx_q) begin
            rdata1_d = g_dout;
          end else begin
            rdata0_d = g_dout;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers with synchronous reset
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b1;
      idx_q    <= 1'b0;
      we_q     <= 1'b0;
      pair_q   <= 1'b0;
      rej_q    <= 1'b0;
      cad_q    <= 5'h0;
      cdat_q   <= 64'h0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      wrb_q    <= 1'b1;
      rdb_q    <= 1'b1;
      addr_q   <= 5'h0;
      din_q    <= 64'h0;
      n9_q     <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      pair_q   <= pair_d;
      rej_q    <= rej_d;
      cad_q    <= cad_d;
      cdat_q   <= cdat_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      wrb_q    <= wrb_d;
      rdb_q    <= rdb_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      n9_q     <= n9_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

`ifdef REG_ARB_RO_GUARD_EN
  // Error pulse register, present only with the write guard
  always_ff @(posedge sysclk) begin
    if (reset) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign err0 = err_q[0];
  assign err1 = err_q[1];
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  assign gnt0         = gnt_q[0];
  assign gnt1         = gnt_q[1];
  assign done0        = done_q[0];
  assign done1        = done_q[1];
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign g_wrb        = wrb_q;
  assign g_rdb        = rdb_q;
  assign g_dout_w0x0f = addr_q;
  assign din          = din_q;
  assign n9_bit_write = n9_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed and randomized checks of reg_bus_arbiter
// against a transaction-level model with a register bank model.
module tb_reg_bus_arbiter;

  typedef struct {
    bit          we;
    bit          wide;
    logic [4:0]  addr;
    logic [63:0] data;
  } op_t;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic        wide0 = 0, wide1 = 0;
  logic [4:0]  addr0 = 0, addr1 = 0;
  logic [63:0] wdata0 = 0, wdata1 = 0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        g_wrb, g_rdb, n9_bit_write;
  logic [4:0]  g_dout_w0x0f;
  logic [63:0] din;
  logic [31:0] g_dout;

  logic [31:0] bank [32];
  logic [31:0] ref_mem [32];
  logic        pre_en = 1'b0;
  logic [4:0]  pre_a = 5'h0;
  logic [31:0] pre_d = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  reg_bus_arbiter dut (
    .sysclk(sysclk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wide0(wide0), .wide1(wide1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .g_wrb(g_wrb), .g_rdb(g_rdb), .g_dout_w0x0f(g_dout_w0x0f),
    .din(din), .n9_bit_write(n9_bit_write), .g_dout(g_dout)
  );

  always #5 sysclk = ~sysclk;

  assign g_dout = g_rdb ? 32'hFFFF_FFFF : bank[g_dout_w0x0f];

  always @(posedge sysclk) begin
    if (pre_en) begin
      bank[pre_a] <= pre_d;
    end else if (g_wrb === 1'b0) begin
      bank[g_dout_w0x0f] <= din[31:0];
      if (n9_bit_write) bank[g_dout_w0x0f + 5'd1] <= din[63:32];
    end
  end

  function automatic bit rejected(bit we, bit wide, logic [4:0] a);
    bit r;
    r = we && (a == 5'h09 || a == 5'h0B || a > 5'h17 || (wide && a[0]));
`ifndef REG_ARB_RO_GUARD_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic present(int n, bit v, op_t o);
    if (n == 0) begin
      req0 = v; we0 = o.we; wide0 = o.wide; addr0 = o.addr; wdata0 = o.data;
    end else begin
      req1 = v; we1 = o.we; wide1 = o.wide; addr1 = o.addr; wdata1 = o.data;
    end
  endtask

  task automatic preload(logic [4:0] a, logic [31:0] d);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    ref_mem[a] = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    op_t z;
    z = '{0, 0, 5'h0, 64'h0};
    present(0, 0, z);
    present(1, 0, z);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [107:0] got;
    logic [107:0] exp;
    present(0, 1, '{1, 1, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF});
    reset = 1'b1;
    tick();
    tick();
    got = {g_wrb, g_rdb, g_dout_w0x0f, din, n9_bit_write,
           gnt0, gnt1, done0, done1, err0, err1, rdata0[0], rdata1[0],
           rdata0[31:1], 2'b00};
    exp = {1'b1, 1'b1, 5'h0, 64'h0, 1'b0, 6'h0, 2'b00, 31'h0, 2'b00};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want %h", got, exp);
    end
    n_cmp++;
    if (rdata1 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdata1 got %h want 0", rdata1);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    op_t o;
    o = '{1, 0, 5'h02, 64'hDEAD_BEEF_A5A5_A5A5};
    present(0, 1, o);
    tick();
    n_cmp++;
    if ({gnt0, gnt1, g_wrb, g_rdb, g_dout_w0x0f, din} !==
        {4'b1011, 5'h02, 64'h0000_0000_A5A5_A5A5}) begin
      n_bad++;
      $display("FAIL wr_setup got %b%b%b%b %h %h", gnt0, gnt1, g_wrb,
               g_rdb, g_dout_w0x0f, din);
    end
    present(0, 0, o);
    tick();
    n_cmp++;
    if ({gnt0, g_wrb, g_rdb, g_dout_w0x0f} !== {3'b001, 5'h02}) begin
      n_bad++;
      $display("FAIL wr_strobe got %b%b%b %h want 001 02", gnt0, g_wrb,
               g_rdb, g_dout_w0x0f);
    end
    tick();
    n_cmp++;
    if ({done0, done1, err0, g_wrb, g_dout_w0x0f} !== {4'b1001, 5'h0}) begin
      n_bad++;
      $display("FAIL wr_done got %b%b%b%b %h want 1001 00", done0, done1,
               err0, g_wrb, g_dout_w0x0f);
    end
    tick();
  endtask

  task automatic test_read();
    op_t o;
    int lows;
    preload(5'h0A, 32'h1234_5678);
    o = '{0, 0, 5'h0A, 64'h0};
    present(1, 1, o);
    lows = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) present(1, 0, o);
      if (g_rdb === 1'b0) lows++;
      if (c == 1) begin
        n_cmp++;
        if ({gnt1, gnt0} !== 2'b10) begin
          n_bad++;
          $display("FAIL rd_gnt got %b%b want 10", gnt1, gnt0);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({done1, done0, rdata1} !== {2'b10, 32'h1234_5678}) begin
          n_bad++;
          $display("FAIL rd_done got %b%b %h want 10 12345678", done1,
                   done0, rdata1);
        end
      end
    end
    n_cmp++;
    if (lows != 1) begin
      n_bad++;
      $display("FAIL rd_strobe_len got %0d want 1", lows);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    do_reset();
    present(0, 1, '{0, 0, 5'h03, 64'h0});
    present(1, 1, '{0, 0, 5'h04, 64'h0});
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = 2'b00;
      if (c % 3 == 1) exp = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if ({gnt1, gnt0} !== exp) begin
        n_bad++;
        $display("FAIL contend_c%0d got %b%b want %b", c, gnt1, gnt0, exp);
      end
      if (c == 12) begin
        req0 = 0;
        req1 = 0;
      end
    end
    tick();
  endtask

  task automatic test_wide_write();
    op_t o;
    o = '{1, 1, 5'h00, 64'h1111_1111_2222_2222};
    present(0, 1, o);
    tick();
    present(0, 0, o);
    n_cmp++;
    if ({n9_bit_write, din} !== {1'b1, o.data}) begin
      n_bad++;
      $display("FAIL wide_setup got %b %h want 1 %h", n9_bit_write, din,
               o.data);
    end
    tick();
    n_cmp++;
    if ({n9_bit_write, g_wrb, din} !== {2'b10, o.data}) begin
      n_bad++;
      $display("FAIL wide_strobe got %b%b %h want 10 %h", n9_bit_write,
               g_wrb, din, o.data);
    end
    tick();
    n_cmp++;
    if ({n9_bit_write, din, done0} !== {1'b0, 64'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL wide_done got %b %h %b", n9_bit_write, din, done0);
    end
    tick();
  endtask

  task automatic test_guard();
    op_t o;
    bit r;
    o = '{1, 0, 5'h09, 64'h5555_5555};
    r = rejected(o.we, o.wide, o.addr);
    present(0, 1, o);
    tick();
    present(0, 0, o);
    tick();
    n_cmp++;
    if (g_wrb !== r) begin
      n_bad++;
      $display("FAIL guard_wrb got %b want %b", g_wrb, r);
    end
    tick();
    n_cmp++;
    if ({done0, err0} !== {1'b1, r}) begin
      n_bad++;
      $display("FAIL guard_done got %b%b want 1%b", done0, err0, r);
    end
    tick();
  endtask

  task automatic test_reset_mid_strobe();
    op_t o;
    o = '{1, 0, 5'h05, 64'h77};
    present(0, 1, o);
    tick();
    present(0, 0, o);
    tick();
    n_cmp++;
    if (g_wrb !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_pre got %b want 0", g_wrb);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({g_wrb, done0} !== 2'b10) begin
      n_bad++;
      $display("FAIL rst_mid_post got %b%b want 10", g_wrb, done0);
    end
    tick();
    n_cmp++;
    if ({done0, done1} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mid_nodone got %b%b want 00", done0, done1);
    end
    present(0, 1, '{0, 0, 5'h01, 64'h0});
    present(1, 1, '{0, 0, 5'h02, 64'h0});
    tick();
    req0 = 0;
    req1 = 0;
    n_cmp++;
    if ({gnt1, gnt0} !== 2'b01) begin
      n_bad++;
      $display("FAIL rst_mid_pref got %b%b want 01", gnt1, gnt0);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_random();
    op_t q0[$];
    op_t q1[$];
    op_t c;
    int order[$];
    int k, ph, cur, last_g, cyc;
    bit crej;
    logic [31:0] cexp;
    logic [4:0] a1;
    do_reset();
    for (int i = 0; i < 32; i++) preload(i[4:0], $urandom);
    for (int n = 0; n < 2; n++) begin
      int cnt;
      cnt = $urandom_range(4, 9);
      for (int j = 0; j < cnt; j++) begin
        op_t o;
        o.we   = 1'($urandom_range(0, 1));
        o.wide = 1'($urandom_range(0, 1));
        o.addr = 5'($urandom_range(0, 31));
        o.data = {$urandom, $urandom};
        if (n == 0) q0.push_back(o);
        else q1.push_back(o);
      end
    end
    begin
      int r0, r1, p, last;
      r0 = q0.size();
      r1 = q1.size();
      last = 1;
      while (r0 + r1 > 0) begin
        if (r0 > 0 && r1 > 0) p = (last == 1) ? 0 : 1;
        else p = (r0 > 0) ? 0 : 1;
        order.push_back(p);
        last = p;
        if (p == 0) r0--;
        else r1--;
      end
    end
    present(0, 1, q0[0]);
    present(1, 1, q1[0]);
    k = 0; ph = 0; cur = 0; last_g = 0; crej = 0; cexp = 0;
    c = q0[0];
    for (cyc = 0; cyc < 400 && !(k == order.size() && ph == 0); cyc++) begin
      tick();
      if (ph == 2) begin
        n_cmp++;
        if ({done1, done0} !== (2'b01 << cur) ||
            {err1, err0} !== (crej ? (2'b01 << cur) : 2'b00)) begin
          n_bad++;
          $display("FAIL rnd_done k%0d got %b%b %b%b", k, done1, done0,
                   err1, err0);
        end
        if (!c.we) begin
          n_cmp++;
          if ((cur == 1 ? rdata1 : rdata0) !== cexp) begin
            n_bad++;
            $display("FAIL rnd_rdata k%0d got %h want %h", k,
                     (cur == 1 ? rdata1 : rdata0), cexp);
          end
        end
        ph = 0;
      end else if (ph == 1) begin
        n_cmp++;
        if ({g_wrb, g_rdb, g_dout_w0x0f} !==
            {!(c.we && !crej), c.we, c.addr}) begin
          n_bad++;
          $display("FAIL rnd_strobe k%0d got %b%b %h want %b%b %h", k,
                   g_wrb, g_rdb, g_dout_w0x0f, !(c.we && !crej), c.we,
                   c.addr);
        end
        ph = 2;
      end
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        n_cmp++;
        if (k >= order.size() ||
            {gnt1, gnt0} !== (2'b01 << order[k]) ||
            (k > 0 && cyc - last_g != 3)) begin
          n_bad++;
          $display("FAIL rnd_grant k%0d got %b%b dt %0d", k, gnt1, gnt0,
                   cyc - last_g);
          $display("FAIL rnd_abort grant order broken, stopping");
          $fatal(1, "grant sequence diverged");
        end
        cur = order[k];
        last_g = cyc;
        if (cur == 0) c = q0.pop_front();
        else c = q1.pop_front();
        crej = rejected(c.we, c.wide, c.addr);
        n_cmp++;
        if ({g_dout_w0x0f, n9_bit_write} !== {c.addr, c.we & c.wide} ||
            (c.we && din !== {c.wide ? c.data[63:32] : 32'h0,
                               c.data[31:0]})) begin
          n_bad++;
          $display("FAIL rnd_setup k%0d got %h %b %h", k, g_dout_w0x0f,
                   n9_bit_write, din);
        end
        if (!c.we) begin
          cexp = ref_mem[c.addr];
        end else if (!crej) begin
          ref_mem[c.addr] = c.data[31:0];
          if (c.wide) begin
            a1 = c.addr + 5'd1;
            ref_mem[a1] = c.data[63:32];
          end
        end
        if (cur == 0) begin
          if (q0.size() > 0) present(0, 1, q0[0]);
          else present(0, 0, c);
        end else begin
          if (q1.size() > 0) present(1, 1, q1[0]);
          else present(1, 0, c);
        end
        ph = 1;
        k++;
      end
    end
    n_cmp++;
    if (!(k == order.size() && ph == 0)) begin
      n_bad++;
      $display("FAIL rnd_timeout done %0d of %0d", k, order.size());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_wide_write();
    test_guard();
    test_reset_mid_strobe();
    test_random();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 The block SHALL have no parameters; the requester count is fixed at 2 (n = 0,1), the address width at 5 bits and the data width at 32 bits.
REQ-002 The block SHALL have port sysclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports req0/req1, input, 1 bit each: requester n wants a register access.
REQ-005 The block SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
REQ-006 The block SHALL have ports wide0/wide1, input, 1 bit each: 64-bit paired write.
REQ-007 The block SHALL have ports addr0/addr1, input, 5 bits each: register index.
REQ-008 The block SHALL have ports wdata0/wdata1, input, 64 bits each: write data; bits [63:32] are used only when wide.
REQ-009 The block SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle grant pulse.
REQ-010 The block SHALL have ports done0/done1, output, 1 bit each: one-cycle completion pulse.
REQ-011 The block SHALL have ports err0/err1, output, 1 bit each: pulses with done when an access is rejected.
REQ-012 The block SHALL have ports rdata0/rdata1, output, 32 bits each: read result.
REQ-013 The block SHALL have port g_wrb, output, 1 bit: active-low write strobe to the register bank.
REQ-014 The block SHALL have port g_rdb, output, 1 bit: active-low read strobe to the register bank.
REQ-015 The block SHALL have port g_dout_w0x0f, output, 5 bits: bank register address.
REQ-016 The block SHALL have port din, output, 64 bits: bank write data.
REQ-017 The block SHALL have port n9_bit_write, output, 1 bit: bank paired-write enable.
REQ-018 The block SHALL have port g_dout, input, 32 bits: bank read data; the bank drives all ones whenever g_rdb = 1.

Function
REQ-019 The state machine SHALL have four states: IDLE, SETUP, STROBE and DONE, and all outputs SHALL be registered.
REQ-020 Arbitration SHALL occur in IDLE and DONE: if any request is high, the selected requester's we, wide, addr and wdata are captured and the next state is SETUP; otherwise the next state is IDLE.
REQ-021 Selection SHALL be round-robin: a sole requester is granted; with both requesting, the requester not granted last wins; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-022 gntN SHALL be high for exactly the SETUP cycle of requester N's access; the requester holds its inputs until it sees gnt and may drop req in the following cycle.
REQ-023 During SETUP, g_dout_w0x0f, din and n9_bit_write (= captured wide) SHALL be driven from the captured request, with both strobes held at 1.
REQ-024 In STROBE, exactly one strobe SHALL be low for one cycle: g_wrb for a write, g_rdb for a read; address, data and n9_bit_write remain stable.
REQ-025 For a read, g_dout SHALL be registered into rdataN at the end of the STROBE cycle; rdataN is otherwise held, and writes leave it unchanged.
REQ-026 In DONE, doneN SHALL pulse for one cycle, rdataN is valid, both strobes are 1, and address, din and n9_bit_write return to 0.
REQ-027 Latency SHALL be 3 cycles from the grant edge to done, and back-to-back accesses SHALL issue every 3 cycles.
REQ-028 A wide read SHALL be treated as a plain 32-bit read with n9_bit_write = 0.
REQ-029 gnt0 and gnt1 SHALL never be high together, and likewise done0/done1 and err0/err1.

Reset
REQ-030 When reset = 1 at a rising edge, the next state SHALL be IDLE and all registered outputs take their reset values, regardless of the current state.
REQ-031 Reset values SHALL be: g_wrb = 1, g_rdb = 1, g_dout_w0x0f = 0, din = 0, n9_bit_write = 0, gnt/done/err = 0, rdata = 0, RR pointer = 1.
REQ-032 If reset occurs during STROBE, the access SHALL be abandoned with no done pulse, and the strobe SHALL be high from the next cycle.

Configuration
REQ-033 When macro REG_ARB_RO_GUARD_EN is defined, a write SHALL be rejected if any of the following holds:
- addr = 5'h09 or 5'h0B (read-only);
- addr > 5'h17;
- wide = 1 with addr[0] = 1.
REQ-034 A rejected write SHALL still pass through SETUP, STROBE and DONE, but with g_wrb held at 1 and errN pulsing together with doneN.
REQ-035 When REG_ARB_RO_GUARD_EN is not defined, all accesses SHALL be issued unchanged and errN SHALL be tied to 0.

Verification
REQ-036 Single write: req0, we0 = 1, addr0 = 5'h02, wdata0 = 0x...A5A5A5A5 -> gnt0 in cycle 1, g_wrb low in cycle 2 with g_dout_w0x0f = 02, done0 in cycle 3, err0 = 0.
REQ-037 Read: req1, we1 = 0, addr1 = 5'h0A, bank returns 0x12345678 -> rdata1 = 0x12345678 at done1, and g_rdb is low for exactly one cycle.
REQ-038 Contention: req0 and req1 held high for 4 accesses -> grants alternate 0,1,0,1, spaced 3 cycles apart, with requester 0 first after reset.
REQ-039 Wide write: addr0 = 5'h00, wide0 = 1, wdata0 = 0x11111111_22222222 -> n9_bit_write = 1 and din = wdata0 during SETUP and STROBE.
REQ-040 Guard: with REG_ARB_RO_GUARD_EN, a write to 5'h09 -> g_wrb stays 1 and err0 = done0 = 1; without the macro, g_wrb pulses low and err0 = 0.
REQ-041 Reset mid-STROBE: assert reset during a write's STROBE cycle -> g_wrb = 1 in the next cycle, no done pulse, and the next request is granted from IDLE with requester 0 preferred.
